// File: rtl/gpio_apb_ctrl.sv
// APB GPIO controller: output pins, synchronised inputs with edge interrupts,
// and a blankable seven-segment driver. Zero-wait-state slave with byte strobes.
module gpio_apb_ctrl #(
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned IN_W        = 16,
    parameter int unsigned SEG_DIGITS  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [31:0]               in_paddr,
    input  logic                      in_psel,
    input  logic                      in_penable,
    input  logic [2:0]                in_pprot,
    input  logic                      in_pwrite,
    input  logic [31:0]               in_pwdata,
    input  logic [3:0]                in_pstrb,
    output logic                      in_pready,
    output logic [31:0]               in_prdata,
    output logic                      in_pslverr,
    output logic [OUT_W-1:0]          gpio_out,
    input  logic [IN_W-1:0]           gpio_in,
    output logic [8*SEG_DIGITS-1:0]   gpio_seg,
    output logic                      irq
);

    localparam int unsigned SEG_W = 4 * SEG_DIGITS;

    localparam logic [2:0] OFF_OUT     = 3'd0;
    localparam logic [2:0] OFF_IN      = 3'd1;
    localparam logic [2:0] OFF_SEG     = 3'd2;
    localparam logic [2:0] OFF_SEG_EN  = 3'd3;
    localparam logic [2:0] OFF_IE_RISE = 3'd4;
    localparam logic [2:0] OFF_IE_FALL = 3'd5;
    localparam logic [2:0] OFF_STAT    = 3'd6;
    localparam logic [2:0] OFF_UNMAP   = 3'd7;

    logic [OUT_W-1:0]      out_q;
    logic [SEG_W-1:0]      seg_q;
    logic [SEG_DIGITS-1:0] seg_en_q;
    logic [IN_W-1:0]       ie_rise_q;
    logic [IN_W-1:0]       ie_fall_q;
    logic [IN_W-1:0]       stat_q;
    logic [IN_W-1:0]       prev_q;
    logic [IN_W-1:0]       sync_q [SYNC_STAGES];

    logic [2:0]  reg_sel;
    logic        access;
    logic        wr_en;
    logic [31:0] lane_mask;
    logic [IN_W-1:0] sync_last;
    logic [IN_W-1:0] stat_set;
    logic [IN_W-1:0] stat_clr;
    logic        unused_bits;

    assign unused_bits = ^{in_pprot, in_paddr[31:5], in_paddr[1:0]};

    assign reg_sel    = in_paddr[4:2];
    assign access     = in_psel & in_penable;
    assign in_pready  = 1'b1;
    assign in_pslverr = access & ((reg_sel == OFF_UNMAP) | ((reg_sel == OFF_IN) & in_pwrite));
    assign wr_en      = access & in_pwrite & ~in_pslverr;

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < 4; b++) begin
            lane_mask[8*b +: 8] = {8{in_pstrb[b]}};
        end
    end

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
            4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
            4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
        endcase
    endfunction

    // Plain RW control registers, byte-lane merged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= '0;
            seg_q     <= '0;
            seg_en_q  <= '1;
            ie_rise_q <= '0;
            ie_fall_q <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                OFF_OUT:     out_q     <= OUT_W'(lane_merge(32'(out_q), in_pwdata, lane_mask));
                OFF_SEG:     seg_q     <= SEG_W'(lane_merge(32'(seg_q), in_pwdata, lane_mask));
                OFF_SEG_EN:  seg_en_q  <= SEG_DIGITS'(lane_merge(32'(seg_en_q), in_pwdata, lane_mask));
                OFF_IE_RISE: ie_rise_q <= IN_W'(lane_merge(32'(ie_rise_q), in_pwdata, lane_mask));
                OFF_IE_FALL: ie_fall_q <= IN_W'(lane_merge(32'(ie_fall_q), in_pwdata, lane_mask));
                default: ;
            endcase
        end
    end

    // Input synchroniser chain plus previous-value register for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_last;
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign stat_set  = (sync_last & ~prev_q & ie_rise_q) | (~sync_last & prev_q & ie_fall_q);
    assign stat_clr  = (wr_en && (reg_sel == OFF_STAT)) ? IN_W'(in_pwdata & lane_mask) : '0;

    // Clear is applied before set so a coincident edge keeps the bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | stat_set;
        end
    end

    always_comb begin
        in_prdata = '0;
        if (in_psel) begin
            case (reg_sel)
                OFF_OUT:     in_prdata = 32'(out_q);
                OFF_IN:      in_prdata = 32'(sync_last);
                OFF_SEG:     in_prdata = 32'(seg_q);
                OFF_SEG_EN:  in_prdata = 32'(seg_en_q);
                OFF_IE_RISE: in_prdata = 32'(ie_rise_q);
                OFF_IE_FALL: in_prdata = 32'(ie_fall_q);
                OFF_STAT:    in_prdata = 32'(stat_q);
                default:     in_prdata = '0;
            endcase
        end
    end

    always_comb begin
        gpio_seg = '1;
        for (int k = 0; k < int'(SEG_DIGITS); k++) begin
            gpio_seg[8*k +: 8] = seg_en_q[k] ? seg7(seg_q[4*k +: 4]) : 8'hFF;
        end
    end

    assign gpio_out = out_q;
    assign irq      = |stat_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Directed bench for gpio_apb_ctrl: register-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_gpio_apb_ctrl;

    localparam int S = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic [63:0] gpio_seg;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    gpio_apb_ctrl #(.OUT_W(16), .IN_W(16), .SEG_DIGITS(8), .SYNC_STAGES(S)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
        .in_pslverr(in_pslverr), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .gpio_seg(gpio_seg), .irq(irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- register-level model ----------------
    logic [7:0]  tab [0:15] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    logic [31:0] m_out, m_seg, m_segen, m_ier, m_ief, m_stat;
    logic [31:0] hist [0:S];   // hist[k] = pin value sampled k+1 edges ago

    function automatic logic [31:0] lanes();
        return {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};
    endfunction

    function automatic logic [31:0] upd(input logic [31:0] old_v, input logic [31:0] width_mask);
        return ((old_v & ~lanes()) | (in_pwdata & lanes())) & width_mask;
    endfunction

    function automatic logic exp_err();
        return in_psel && in_penable &&
               (in_paddr[4:2] == 3'd7 || (in_paddr[4:2] == 3'd1 && in_pwrite));
    endfunction

    function automatic logic model_wr(input int off);
        return in_psel && in_penable && in_pwrite && !exp_err() && int'(in_paddr[4:2]) == off;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!in_psel) return 32'h0;
        case (in_paddr[4:2])
            3'd0: return m_out;
            3'd1: return hist[S-1];
            3'd2: return m_seg;
            3'd3: return m_segen;
            3'd4: return m_ier;
            3'd5: return m_ief;
            3'd6: return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] exp_seg();
        logic [63:0] r;
        r = '1;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = m_segen[k] ? tab[m_seg[4*k +: 4]] : 8'hFF;
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_out <= 0; m_seg <= 0; m_segen <= 32'hFF; m_ier <= 0; m_ief <= 0; m_stat <= 0;
            for (int i = 0; i <= S; i++) hist[i] <= 0;
        end else begin
            hist[0] <= 32'(gpio_in);
            for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
            if (model_wr(0)) m_out   <= upd(m_out, 32'h0000_FFFF);
            if (model_wr(2)) m_seg   <= upd(m_seg, 32'hFFFF_FFFF);
            if (model_wr(3)) m_segen <= upd(m_segen, 32'h0000_00FF);
            if (model_wr(4)) m_ier   <= upd(m_ier, 32'h0000_FFFF);
            if (model_wr(5)) m_ief   <= upd(m_ief, 32'h0000_FFFF);
            // edge seen when visible value differs from the one a cycle earlier
            m_stat <= ((m_stat & ~(model_wr(6) ? (in_pwdata & lanes()) : 32'h0))
                       | (hist[S-1] & ~hist[S] & m_ier)
                       | (~hist[S-1] & hist[S] & m_ief)) & 32'h0000_FFFF;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("cyc_gpio_out", 64'(gpio_out), 64'(m_out[15:0]));
            chk("cyc_gpio_seg", gpio_seg, exp_seg());
            chk("cyc_irq", 64'(irq), 64'(m_stat != 0));
            chk("cyc_pready", 64'(in_pready), 64'd1);
            chk("cyc_prdata", 64'(in_prdata), 64'(exp_rd()));
            chk("cyc_pslverr", 64'(in_pslverr), 64'(exp_err()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
        @(posedge clock); #2;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr;
        in_paddr = addr; in_pwdata = wdata; in_pstrb = strb;
        @(posedge clock); #2;
        in_penable = 1'b1;
        @(negedge clock);
        rd = in_prdata;
        err = in_pslverr;
        @(posedge clock); #2;
        in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] rd;
        logic err;
        apb(1'b1, addr, wdata, strb, rd, err);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        apb(1'b0, addr, 32'h0, 4'h0, rd, err);
        chk(name, 64'(rd), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        reset_n = 1'b0;
        in_paddr = 0; in_psel = 0; in_penable = 0; in_pprot = 0;
        in_pwrite = 0; in_pwdata = 0; in_pstrb = 0; gpio_in = 0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        started = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_seg", gpio_seg, 64'h0303_0303_0303_0303);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_out", 64'(gpio_out), 64'd0);
        rd_chk("rst_OUT", 32'h1000_2000, 32'h0);
        rd_chk("rst_SEG", 32'h1000_2008, 32'h0);
        rd_chk("rst_SEG_EN", 32'h1000_200C, 32'hFF);
        rd_chk("rst_STAT", 32'h1000_2018, 32'h0);

        // Byte strobes and width truncation
        wr32(32'h1000_2000, 32'h1234_ABCD, 4'b0001);
        rd_chk("out_strb0", 32'h1000_2000, 32'h0000_00CD);
        wr32(32'h1000_2000, 32'h1234_ABCD, 4'b0010);
        rd_chk("out_strb1", 32'h1000_2000, 32'h0000_ABCD);
        chk("gpio_out_abcd", 64'(gpio_out), 64'h0000_ABCD);
        wr32(32'h1000_2000, 32'hDEAD_1234, 4'b1111);
        rd_chk("out_trunc", 32'h1000_2000, 32'h0000_1234);

        // Segment decode and blanking
        wr32(32'h1000_2008, 32'h89AB_CDEF, 4'b1111);
        wr32(32'h1000_200C, 32'h0000_00F0, 4'b1111);
        @(negedge clock);
        chk("seg_pattern", gpio_seg, 64'h0109_11C1_FFFF_FFFF);
        rd_chk("seg_en_rd", 32'h1000_200C, 32'h0000_00F0);

        // Rising edge interrupt timing: pin changes just after edge P0
        wr32(32'h1000_2010, 32'h0000_0001, 4'b1111);
        @(posedge clock); #2;
        gpio_in = 16'h0001;
        in_psel = 1'b1; in_paddr = 32'h1000_2004;
        @(posedge clock); @(negedge clock);
        chk("in_t1", 64'(in_prdata), 64'd0);
        @(posedge clock); @(negedge clock);
        chk("in_t2", 64'(in_prdata), 64'd1);
        chk("irq_t2", 64'(irq), 64'd0);
        @(posedge clock); @(negedge clock);
        chk("irq_t3", 64'(irq), 64'd1);
        @(posedge clock); #2;
        in_psel = 1'b0;
        wr32(32'h1000_2018, 32'h0000_0001, 4'b0000);
        @(negedge clock);
        chk("w1c_nostrb", 64'(irq), 64'd1);
        wr32(32'h1000_2018, 32'h0000_0001, 4'b0001);
        @(negedge clock);
        chk("w1c_clear", 64'(irq), 64'd0);

        // Disabled edge is not recovered by enabling later
        gpio_in = 16'h0005;
        idle(5);
        wr32(32'h1000_2010, 32'h0000_0005, 4'b1111);
        idle(3);
        rd_chk("missed_edge", 32'h1000_2018, 32'h0);

        // Falling edge coincident with W1C: set wins
        gpio_in = 16'h0007;
        idle(5);
        wr32(32'h1000_2014, 32'h0000_0002, 4'b1111);
        @(posedge clock); #2;
        gpio_in = 16'h0005;
        wr32(32'h1000_2018, 32'h0000_0002, 4'b1111);
        rd_chk("set_wins", 32'h1000_2018, 32'h0000_0002);
        wr32(32'h1000_2018, 32'h0000_0002, 4'b1111);
        rd_chk("stat_cleared", 32'h1000_2018, 32'h0);

        // Error responses
        apb(1'b1, 32'h1000_2004, 32'hFFFF_FFFF, 4'hF, rd, err);
        chk("err_wr_in", 64'(err), 64'd1);
        rd_chk("in_unchanged", 32'h1000_2004, 32'h0000_0005);
        apb(1'b0, 32'h1000_201C, 32'h0, 4'h0, rd, err);
        chk("err_rd_1c", 64'(err), 64'd1);
        chk("rd_1c_zero", 64'(rd), 64'd0);
        apb(1'b1, 32'h1000_201C, 32'h0000_0000, 4'hF, rd, err);
        chk("err_wr_1c", 64'(err), 64'd1);
        rd_chk("out_after_err", 32'h1000_2000, 32'h0000_1234);

        // Reset asserted during the access phase of a write
        @(posedge clock); #2;
        in_psel = 1'b1; in_pwrite = 1'b1; in_paddr = 32'h1000_2000;
        in_pwdata = 32'h0000_FFFF; in_pstrb = 4'hF;
        @(posedge clock); #2;
        in_penable = 1'b1;
        #3 reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_out", 64'(gpio_out), 64'd0);
        chk("midrst_seg", gpio_seg, 64'h0303_0303_0303_0303);
        @(posedge clock); #2;
        in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b1;
        rd_chk("post_rst_OUT", 32'h1000_2000, 32'h0);
        rd_chk("post_rst_SEG_EN", 32'h1000_200C, 32'hFF);
        rd_chk("post_rst_IE_RISE", 32'h1000_2010, 32'h0);
        idle(4);
        rd_chk("post_rst_STAT", 32'h1000_2018, 32'h0);
        chk("post_rst_irq", 64'(irq), 64'd0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
